alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 16-bit `alu` datapath between two requesters, e.g. the PC-increment path and the register-file datapath of the multi-cycle processor. Each requester uses a valid/ready handshake. The block picks one requester, latches its `op`/`a`/`b`, and drives the ALU from registers. It then captures `Result`/`co`/`zero`/`overflow` and returns them with a one-cycle response pulse to the winning requester. Sits between the control unit and the `alu` instance.

## Interface
- `WIDTH`, 16, operand/result width; must match `alu`.
- `OPW`, 3, ALU opcode width.

- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 2: per-requester request valid; bit i = requester i.
- `req_ready` output 2: per-requester accept; at most one bit high.
- `req_op0`, `req_op1` input OPW: opcode from requester 0/1.
- `req_a0`, `req_a1`, `req_b0`, `req_b1` input WIDTH: operands.
- `rsp_valid` output 2: one-cycle pulse to the requester whose op completed.
- `rsp_result` output WIDTH: captured ALU `Result`.
- `rsp_co`, `rsp_zero`, `rsp_overflow` output 1: captured flags.
- `alu_op` output OPW: to `alu.op`.
- `alu_a`, `alu_b` output WIDTH: to `alu.a`, `alu.b`.
- `alu_result` input WIDTH: from `alu.Result`.
- `alu_co`, `alu_zero`, `alu_overflow` input 1: from `alu`.
- `busy` output 1: high in EXEC.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE → EXEC on accept.
  - EXEC → DONE unconditionally.
  - DONE → EXEC on accept, otherwise DONE → IDLE.
- An accept may occur only in IDLE or DONE. Accept is `req_valid[i] & req_ready[i]`.
- `req_ready[i]` = (state is IDLE or DONE) and grant == i.
  - Grant is combinational from `req_valid` and `last`.
  - `req_ready` may depend on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- On accept:
  - latch the granted op/a/b into `alu_op`/`alu_a`/`alu_b` registers;
  - record `id` = i;
  - set `last` = i.
- In EXEC, the ALU is combinational off the registered operands. At the end of EXEC, capture `alu_result` and the three flags into the `rsp_*` registers.
- In DONE, `rsp_valid[id]` = 1; the other bit is 0. There is no response backpressure.
- The `rsp_*` data registers hold their value until the next capture. The `alu_*` registers hold until the next accept.
- Grant when only one requester is valid: that requester.
- Grant when both are valid: set by the macro; see Configuration.
- A requester whose valid is held and not granted keeps waiting; its inputs must stay stable until accepted.

## Timing
- Accept in cycle N → ALU driven N+1 → `rsp_valid` high in N+2 only.
- Throughput: one op every 2 cycles under back-to-back requests, because an accept in DONE overlaps the response.
- Reset values:
  - state IDLE, `busy` 0;
  - `req_ready` follows IDLE rules, so it is combinationally live immediately after reset;
  - `rsp_valid` 0, `rsp_result` 0, all `rsp_*` flags 0;
  - `alu_op` 0, `alu_a` 0, `alu_b` 0;
  - `last` = 1, so requester 0 wins the first conflict;
  - `id` = 0.
- Reset asserted in EXEC or DONE aborts the op: no `rsp_valid` on the next cycle, and the state returns to IDLE.
- A request that drops valid without being accepted has no effect.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On conflict, grant the requester ≠ `last`.
- Not defined: fixed priority. Requester 0 always wins a conflict, and `last` is still tracked but unused.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum (IDLE, EXEC, DONE);
  - `WIDTH` and `OPW` default constants;
  - the requester-count constant (2).
- One sub-module, `alu_arb_pick`:
  - inputs `req_valid[1:0]`, `last`;
  - output one-hot `grant[1:0]`;
  - contains the `ALU_ARB_RR_EN` selection.
- The FSM, operand registers and response registers stay in `alu_arbiter`.

## Test plan
The bench drives the ALU ports from a behavioural model: op 0 = a+b with `co`/`zero`/`overflow`.
- **Single request:** requester 0 asserts valid with op 0, a=100, b=120 → `req_ready[0]`=1 in that cycle; `alu_a`=100 at N+1; `rsp_valid`=2'b01 at N+2 only; `rsp_result`=220, `co`=0, `zero`=0.
- **Flags:** requester 1 sends op 0, a=16'hFFFF, b=1 → `rsp_valid`=2'b10 with `rsp_result`=0, `rsp_co`=1, `rsp_zero`=1.
- **Conflict:** both requesters held valid for 8 cycles, operands r0=(1,1) and r1=(2,2).
  - With `ALU_ARB_RR_EN`: responses alternate r0, r1, r0, r1 on every 2nd cycle, with results 2, 4, 2, 4.
  - Without it: responses are r0 only.
- **Back-to-back:** requester 0 keeps valid high with new operands after each accept → accepts occur every 2 cycles, and `rsp_valid[0]` pulses every 2 cycles.
- **Reset mid-op:** assert `reset` in the EXEC cycle of a=5, b=6 → no `rsp_valid` afterwards; all outputs at reset values the cycle after; next request completes normally.
- **Idle:** no valid for 10 cycles → `busy`=0, `rsp_valid`=0, `rsp_result` unchanged.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arbiter shared types and default sizes.
// Imported by alu_arb_pick and alu_arbiter.
package alu_arb_pkg;

   localparam int WIDTH_D = 16;
   localparam int OPW_D   = 3;
   localparam int NREQ    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Grant selection for alu_arbiter; one-hot grant from valid and last winner.
// ALU_ARB_RR_EN selects round-robin on conflict, else requester 0 wins.
module alu_arb_pick
   import alu_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_valid,
   input  logic            last,
   output logic [NREQ-1:0] grant
);

`ifdef ALU_ARB_RR_EN
   always_comb begin
      grant = '0;
      unique case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end
`else
   logic w_unused_last;
   assign w_unused_last = last;

   always_comb begin
      grant = '0;
      unique case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = 2'b01;
         default: grant = '0;
      endcase
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, one op per 2 cycles.
// Conflict policy: ALU_ARB_RR_EN defined = round-robin, else fixed priority.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_D,
   parameter int OPW   = OPW_D
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [OPW-1:0]   req_op0,
   input  logic [OPW-1:0]   req_op1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_co,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_co,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             busy
);

   state_t           r_state;
   state_t           w_next;
   logic             r_last;
   logic             r_id;
   logic [OPW-1:0]   r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_co;
   logic             r_zero;
   logic             r_ovf;
   logic [NREQ-1:0]  w_grant;
   logic             w_open;
   logic             w_acc;
   logic             w_sel;

   alu_arb_pick u_pick (
      .req_valid (req_valid),
      .last      (r_last),
      .grant     (w_grant)
   );

   assign w_open    = (r_state == IDLE) || (r_state == DONE);
   assign req_ready = w_open ? w_grant : '0;
   assign w_acc     = |(req_valid & req_ready);
   assign w_sel     = w_grant[1];

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_acc) w_next = EXEC;
         EXEC:    w_next = DONE;
         DONE:    w_next = w_acc ? EXEC : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_co    <= 1'b0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_id   <= w_sel;
            r_last <= w_sel;
            r_op   <= w_sel ? req_op1 : req_op0;
            r_a    <= w_sel ? req_a1  : req_a0;
            r_b    <= w_sel ? req_b1  : req_b0;
         end
         // ALU settles during EXEC off the registered operands
         if (r_state == EXEC) begin
            r_res  <= alu_result;
            r_co   <= alu_co;
            r_zero <= alu_zero;
            r_ovf  <= alu_overflow;
         end
      end
   end

   assign alu_op       = r_op;
   assign alu_a        = r_a;
   assign alu_b        = r_b;
   assign rsp_result   = r_res;
   assign rsp_co       = r_co;
   assign rsp_zero     = r_zero;
   assign rsp_overflow = r_ovf;
   assign busy         = (r_state == EXEC);
   assign rsp_valid    = (r_state == DONE) ?
                         (r_id ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural adder standing in for alu.
// Conflict expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [2:0]  req_op0, req_op1;
   logic [15:0] req_a0, req_a1, req_b0, req_b1;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_result;
   logic        rsp_co, rsp_zero, rsp_overflow;
   logic [2:0]  alu_op;
   logic [15:0] alu_a, alu_b;
   logic [15:0] alu_result;
   logic        alu_co, alu_zero, alu_overflow;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op0      (req_op0),
      .req_op1      (req_op1),
      .req_a0       (req_a0),
      .req_a1       (req_a1),
      .req_b0       (req_b0),
      .req_b1       (req_b1),
      .rsp_valid    (rsp_valid),
      .rsp_result   (rsp_result),
      .rsp_co       (rsp_co),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_co       (alu_co),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .busy         (busy)
   );

   // op 0 = add; other opcodes return zero
   always_comb begin
      alu_result   = '0;
      alu_co       = 1'b0;
      alu_overflow = 1'b0;
      if (alu_op == 3'd0) begin
         {alu_co, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
         alu_overflow = (alu_a[15] == alu_b[15]) &&
                        (alu_result[15] != alu_a[15]);
      end
      alu_zero = (alu_result == 16'd0);
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int          c_off[$];
   int          c_rv[$];
   logic [15:0] c_res[$];
   int          e_rv[4];
   logic [15:0] e_res[4];
   int          n_acc, n_rsp;
   logic [15:0] held;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      req_valid = 2'b00;
      req_op0 = 3'd0; req_op1 = 3'd0;
      req_a0 = 16'd0; req_a1 = 16'd0;
      req_b0 = 16'd0; req_b1 = 16'd0;
      repeat (2) @(posedge clk);
      #1;

      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_result", rsp_result, 0);
      check("rst_flags", {rsp_co, rsp_zero, rsp_overflow}, 0);
      check("rst_alu", {alu_op, alu_a, alu_b}, 0);
      req_valid = 2'b11;
      #1 check("rst_ready_conflict", req_ready, 2'b01);
      req_valid = 2'b10;
      #1 check("rst_ready_r1", req_ready, 2'b10);
      req_valid = 2'b00;
      #1 check("rst_ready_none", req_ready, 2'b00);
      reset = 1'b0;
      step();

      // single request
      req_op0 = 3'd0; req_a0 = 16'd100; req_b0 = 16'd120;
      req_valid = 2'b01;
      #1 check("single_ready", req_ready, 2'b01);
      step();
      req_valid = 2'b00;
      check("single_alu_a", alu_a, 16'd100);
      check("single_alu_b", alu_b, 16'd120);
      check("single_busy", busy, 1);
      check("single_rv_n1", rsp_valid, 2'b00);
      check("single_ready_exec", req_ready, 2'b00);
      step();
      check("single_rv_n2", rsp_valid, 2'b01);
      check("single_result", rsp_result, 16'd220);
      check("single_co", rsp_co, 0);
      check("single_zero", rsp_zero, 0);
      step();
      check("single_rv_n3", rsp_valid, 2'b00);
      check("single_hold", rsp_result, 16'd220);

      // flags
      req_op1 = 3'd0; req_a1 = 16'hFFFF; req_b1 = 16'd1;
      req_valid = 2'b10;
      #1 check("flags_ready", req_ready, 2'b10);
      step();
      req_valid = 2'b00;
      step();
      check("flags_rv", rsp_valid, 2'b10);
      check("flags_result", rsp_result, 16'd0);
      check("flags_co", rsp_co, 1);
      check("flags_zero", rsp_zero, 1);
      check("flags_ovf", rsp_overflow, 0);
      step();

      // conflict: r0=(1,1) r1=(2,2), both valid 8 cycles
      req_a0 = 16'd1; req_b0 = 16'd1;
      req_a1 = 16'd2; req_b1 = 16'd2;
`ifdef ALU_ARB_RR_EN
      e_rv = '{1, 2, 1, 2};
      e_res = '{16'd2, 16'd4, 16'd2, 16'd4};
`else
      e_rv = '{1, 1, 1, 1};
      e_res = '{16'd2, 16'd2, 16'd2, 16'd2};
`endif
      for (int k = 0; k < 11; k++) begin
         req_valid = (k < 8) ? 2'b11 : 2'b00;
         #1;
         if (rsp_valid != 2'b00) begin
            c_off.push_back(k);
            c_rv.push_back(int'(rsp_valid));
            c_res.push_back(rsp_result);
         end
         step();
      end
      check("conf_count", c_off.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < c_off.size()) begin
            check($sformatf("conf_off%0d", i), c_off[i], 2 * (i + 1));
            check($sformatf("conf_rv%0d", i), c_rv[i], e_rv[i]);
            check($sformatf("conf_res%0d", i), c_res[i], e_res[i]);
         end
      end

      // back-to-back on requester 0
      n_acc = 0;
      n_rsp = 0;
      for (int k = 0; k < 12; k++) begin
         req_a0 = 16'(10 * (n_acc + 1));
         req_b0 = 16'(n_acc + 1);
         req_valid = (n_acc < 4) ? 2'b01 : 2'b00;
         #1;
         if (rsp_valid != 2'b00) begin
            check("b2b_rv", rsp_valid, 2'b01);
            check("b2b_rsp_cyc", k, 2 * (n_rsp + 1));
            check("b2b_res", rsp_result, 16'(11 * (n_rsp + 1)));
            n_rsp++;
         end
         if (req_valid[0] && req_ready[0]) begin
            check("b2b_acc_cyc", k, 2 * n_acc);
            n_acc++;
         end
         step();
      end
      check("b2b_n_acc", n_acc, 4);
      check("b2b_n_rsp", n_rsp, 4);

      // reset in EXEC
      req_a0 = 16'd5; req_b0 = 16'd6;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      check("rmid_busy", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rmid_rv", rsp_valid, 2'b00);
      check("rmid_busy0", busy, 0);
      check("rmid_result", rsp_result, 0);
      check("rmid_alu", {alu_op, alu_a, alu_b}, 0);
      step();
      check("rmid_rv2", rsp_valid, 2'b00);
      req_a0 = 16'd7; req_b0 = 16'd8;
      req_valid = 2'b01;
      #1 check("rmid_ready", req_ready, 2'b01);
      step();
      req_valid = 2'b00;
      step();
      check("rmid_next_rv", rsp_valid, 2'b01);
      check("rmid_next_res", rsp_result, 16'd15);
      step();

      // idle
      held = rsp_result;
      for (int k = 0; k < 10; k++) begin
         check("idle_busy", busy, 0);
         check("idle_rv", rsp_valid, 2'b00);
         step();
      end
      check("idle_hold", rsp_result, held);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
